// File: rtl/div_32bit_seq.sv
// Multicycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, result re-signed on completion.
module div_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             sign_q;
  logic             dbz_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_neg;

  always_comb begin
    abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    // Shifted remainder minus divisor; one extra bit keeps the sign of the trial exact.
    trial   = {rem_q, quo_q[WIDTH-1]} + ~{2'b00, div_q} + (WIDTH+2)'(1);
    fits    = ~trial[WIDTH+1];
    rem_d   = fits ? trial[WIDTH:0] : {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    quo_d   = {quo_q[WIDTH-2:0], fits};
    quo_neg = ~quo_d + WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_DIV) begin
        // A start in any state discards whatever was in flight.
        state_q <= RUN;
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= abs_a;
        div_q   <= abs_b;
        sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dbz_q   <= (data_operandB == '0);
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q  <= DONE;
              rdy_q    <= 1'b1;
              exc_q    <= dbz_q;
              result_q <= dbz_q ? '0 : (sign_q ? quo_neg : quo_d);
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Bench for div_32bit_seq: directed vector table, multi-cycle corner sequences
// and random signed operands against an arithmetic reference.
module tb_div_32bit_seq;

  logic        clock;
  logic        reset;
  logic        ctrl;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] result;
  logic        exception;
  logic        rdy;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_32bit_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (result),
    .data_exception (exception),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        exc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Truncating signed division computed on wide integers; divide-by-zero yields 0.
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    if (b == 32'd0) return 32'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return q[31:0];
  endfunction

  // Start one op on the next edge and wait (bounded) for its RDY pulse.
  // lat counts cycles after the start cycle; 0 means no pulse was seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc,
                        output int lat, output int busy_bad);
    @(negedge clock);
    ctrl = 1'b1; opa = a; opb = b;
    lat = 0; busy_bad = 0; res = '0; exc = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clock);
      ctrl = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (rdy === 1'b1) begin
        lat = c; res = result; exc = exception;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          busy_bad;
    int          pulses;
    int          pulse_cyc;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0};
    vecs[2]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0};
    vecs[3]  = '{32'd7,          32'd100,        32'd0,          1'b0};
    vecs[4]  = '{32'd5,          32'd0,          32'd0,          1'b1};
    vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0};
    vecs[6]  = '{32'h80000000,   32'd2,          32'hC0000000,   1'b0};
    vecs[7]  = '{32'd0,          32'd5,          32'd0,          1'b0};
    vecs[8]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
    vecs[9]  = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'd1,          1'b0};
    vecs[10] = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[11] = '{32'h80000000,   32'h80000000,   32'd1,          1'b0};
    vecs[12] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};

    reset = 1'b1; ctrl = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clock);
    check("reset_result", result, 32'd0);
    check("reset_exc", {31'd0, exception}, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Directed vectors with latency, busy window and post-pulse checks.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, exc, lat, busy_bad);
      check($sformatf("vec%0d_result", i), res, vecs[i].q);
      check($sformatf("vec%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].exc});
      check($sformatf("vec%0d_latency", i), lat, 33);
      check($sformatf("vec%0d_busy_window", i), busy_bad, 0);
      @(negedge clock);
      check($sformatf("vec%0d_rdy_drop", i), {31'd0, rdy}, 32'd0);
      check($sformatf("vec%0d_busy_drop", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_hold", i), result, vecs[i].q);
    end

    // Restart mid-op: 100/7 then 81/9 at cycle 10; one pulse at cycle 43.
    @(negedge clock);
    ctrl = 1'b1; opa = 32'd100; opb = 32'd7;
    pulses = 0; pulse_cyc = 0; res = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      ctrl = 1'b0;
      if (rdy === 1'b1) begin
        pulses++; pulse_cyc = c; res = result;
      end
      if (c == 10) begin
        ctrl = 1'b1; opa = 32'd81; opb = 32'd9;
      end
      if (c == 44) check("restart_busy_drop", {31'd0, busy}, 32'd0);
    end
    check("restart_pulses", pulses, 1);
    check("restart_cycle", pulse_cyc, 43);
    check("restart_result", res, 32'd9);

    // Start in the DONE cycle: old result still pulses, new op follows.
    run_op(32'd100, 32'd7, res, exc, lat, busy_bad);
    check("done_start_first", res, 32'd14);
    check("done_start_first_lat", lat, 33);
    ctrl = 1'b1; opa = 32'd81; opb = 32'd9;
    lat = 0; res = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clock);
      ctrl = 1'b0;
      if (c == 1) check("done_start_busy", {31'd0, busy}, 32'd1);
      if (rdy === 1'b1) begin
        lat = c; res = result;
      end
    end
    check("done_start_second", res, 32'd9);
    check("done_start_second_lat", lat, 33);

    // Reset mid-op at cycle 15 aborts with no pulse and clears outputs.
    @(negedge clock);
    ctrl = 1'b1; opa = 32'd100; opb = 32'd7;
    pulses = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      ctrl = 1'b0;
      if (rdy === 1'b1) pulses++;
      if (c == 15) reset = 1'b1;
      if (c == 16) begin
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_exc", {31'd0, exception}, 32'd0);
      end
    end
    check("abort_pulses", pulses, 0);

    // Reset and start together: reset wins.
    @(negedge clock);
    reset = 1'b1; ctrl = 1'b1; opa = 32'd9; opb = 32'd3;
    @(negedge clock);
    reset = 1'b0; ctrl = 1'b0;
    check("reset_wins_busy", {31'd0, busy}, 32'd0);

    // Random signed operands with assorted magnitudes.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
      if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      if (b == 32'd0) b = 32'd1;
      run_op(a, b, res, exc, lat, busy_bad);
      check($sformatf("rand%0d_result a=%h b=%h", i, a, b), res, ref_q(a, b));
      check($sformatf("rand%0d_exc", i), {31'd0, exc}, 32'd0);
      check($sformatf("rand%0d_latency", i), lat, 33);
      check($sformatf("rand%0d_busy", i), busy_bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
